// File: rtl/io_pkg.sv
// io_pkg: shared button-FSM states and MMIO map for the button/switch block
package io_pkg;
  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} btn_state_e;
  localparam logic [3:0] IO_OFF_LEVEL = 4'h0;
  localparam logic [3:0] IO_OFF_PRESS = 4'h4;
  localparam logic [3:0] IO_OFF_SW = 4'h8;
  localparam logic [3:0] IO_OFF_CFG = 4'hC;
  localparam logic [31:0] IO_BTN_BASE = 32'h0000_7800;
endpackage

// File: rtl/db_channel.sv
// db_channel: one button synchronizer plus debounce FSM and counter
module db_channel
  import io_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DB_CYCLES);
  logic [1:0] sync;
  logic sample, done;
  btn_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  assign sample = sync[1];
  // entering PEND already counts the first differing sample, so the flip lands on sample DB_CYCLES
  assign done = (cnt + CW'(1)) == CW'(DB_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync <= '0;
      state <= STABLE_LO;
      cnt <= '0;
    end else begin
      sync <= {sync[0], raw};
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    case (state)
      STABLE_LO: if (sample) begin
        state_nxt = PEND_HI;
        cnt_nxt = '0;
      end
      PEND_HI: if (!sample) state_nxt = STABLE_LO;
        else if (done) state_nxt = STABLE_HI;
        else cnt_nxt = cnt + CW'(1);
      STABLE_HI: if (!sample) begin
        state_nxt = PEND_LO;
        cnt_nxt = '0;
      end
      PEND_LO: if (sample) state_nxt = STABLE_HI;
        else if (done) state_nxt = STABLE_LO;
        else cnt_nxt = cnt + CW'(1);
      default: state_nxt = STABLE_LO;
    endcase
  end
  assign level = (state == STABLE_HI) || (state == PEND_LO);
  assign rise = (state == PEND_HI) && sample && done;
endmodule

// File: rtl/io_btn_debounce.sv
// io_btn_debounce: debounced buttons, synchronized switches and their MMIO registers
module io_btn_debounce
  import io_pkg::*;
#(
  parameter int NUM_BTN = 4,
  parameter int DB_CYCLES = 16,
  parameter int SW_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_BTN-1:0]  i_btn_raw,
  input  logic [SW_WIDTH-1:0] i_sw_raw,
  input  logic                i_wr_en,
  input  logic [3:0]          i_addr,
  input  logic [31:0]         i_wdata,
  output logic [31:0]         o_rdata,
  output logic [NUM_BTN-1:0]  o_btn_db,
  output logic [SW_WIDTH-1:0] o_sw_sync,
  output logic                o_press_pend
);
  logic [SW_WIDTH-1:0] sw_meta;
  logic [NUM_BTN-1:0] rise, press, clr;
  logic [1:0] sel;
  logic unused;
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    db_channel #(.DB_CYCLES(DB_CYCLES)) u_ch (
      .clk  (clk),
      .rstn (rstn),
      .raw  (i_btn_raw[g]),
      .level(o_btn_db[g]),
      .rise (rise[g])
    );
  end
  assign sel = i_addr[3:2];
  assign clr = (i_wr_en && sel == IO_OFF_PRESS[3:2]) ? i_wdata[NUM_BTN-1:0] : '0;
  // a new press in the same cycle as its W1C clear survives
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sw_meta <= '0;
      o_sw_sync <= '0;
      press <= '0;
    end else begin
      sw_meta <= i_sw_raw;
      o_sw_sync <= sw_meta;
      press <= (press & ~clr) | rise;
    end
  end
  assign o_press_pend = |press;
  always_comb begin
    o_rdata = sel == IO_OFF_LEVEL[3:2] ? 32'(o_btn_db) :
              sel == IO_OFF_PRESS[3:2] ? 32'(press) :
              sel == IO_OFF_SW[3:2] ? 32'(o_sw_sync) : 32'(DB_CYCLES);
  end
  assign unused = ^{i_addr[1:0], i_wdata};
endmodule

// File: tb/tb_io_btn_debounce.sv
// tb_io_btn_debounce: randomized scoreboard bench against a run-length debounce model
module tb_io_btn_debounce;
  localparam int NB = 4;
  localparam int DB = 16;
  localparam int SW = 32;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic wr_en = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [SW-1:0] sw_raw = '0;
  logic [3:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [NB-1:0] btn_db;
  logic [SW-1:0] sw_sync;
  logic press_pend;
  always #5 clk = ~clk;
  io_btn_debounce #(.NUM_BTN(NB), .DB_CYCLES(DB), .SW_WIDTH(SW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_btn_raw   (btn_raw),
    .i_sw_raw    (sw_raw),
    .i_wr_en     (wr_en),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_rdata     (rdata),
    .o_btn_db    (btn_db),
    .o_sw_sync   (sw_sync),
    .o_press_pend(press_pend)
  );
  typedef struct {
    logic [NB-1:0] db;
    logic [SW-1:0] sw;
    logic pend;
    logic [31:0] rd;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int run[NB];
  logic [NB-1:0] lvl = '0, m_press = '0, bs1 = '0, bs2 = '0;
  logic [SW-1:0] ss1 = '0, ss2 = '0;
  logic nr = 1'b0, nw = 1'b0;
  logic [NB-1:0] nb = '0;
  logic [SW-1:0] ns = '0;
  logic [3:0] na = '0;
  logic [31:0] nd = '0;
  // a level flips after DB consecutive synchronized samples differ from it
  function automatic void model_edge();
    logic [NB-1:0] rs = '0;
    logic [NB-1:0] cl;
    if (!rstn) begin
      lvl = '0; m_press = '0; bs1 = '0; bs2 = '0; ss1 = '0; ss2 = '0;
      for (int i = 0; i < NB; i++) run[i] = 0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (bs2[i] != lvl[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            lvl[i] = ~lvl[i];
            run[i] = 0;
            rs[i] = lvl[i];
          end
        end else run[i] = 0;
      end
      cl = (wr_en && addr[3:2] == 2'd1) ? wdata[NB-1:0] : '0;
      m_press = (m_press & ~cl) | rs;
      bs2 = bs1; bs1 = btn_raw; ss2 = ss1; ss1 = sw_raw;
    end
  endfunction
  function automatic exp_t expect_now();
    exp_t x;
    x.db = lvl;
    x.sw = ss2;
    x.pend = |m_press;
    case (addr[3:2])
      2'd0: x.rd = 32'(lvl);
      2'd1: x.rd = 32'(m_press);
      2'd2: x.rd = 32'(ss2);
      default: x.rd = 32'(DB);
    endcase
    return x;
  endfunction
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      rstn = nr; btn_raw = nb; sw_raw = ns; wr_en = nw; addr = na; wdata = nd;
      q.push_back(expect_now());
    end
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("btn_db", 32'(btn_db), 32'(e.db));
      chk("sw_sync", sw_sync, e.sw);
      chk("press_pend", 32'(press_pend), 32'(e.pend));
      chk("rdata", rdata, e.rd);
    end
  end
  initial begin
    tick(3);
    nr = 1'b1; na = 4'h4;
    tick(1);
    nb[0] = 1'b1;
    tick(17);
    nw = 1'b1; nd = 32'h1;
    tick(1);
    nw = 1'b0;
    tick(3);
    nw = 1'b1;
    tick(1);
    nw = 1'b0;
    tick(2);
    for (int k = 0; k < 12; k++) begin
      nb[1] = ~nb[1];
      tick(5);
    end
    nb[1] = 1'b1;
    tick(25);
    ns = 32'hA5A5_0F0F; na = 4'h8;
    tick(4);
    na = 4'hC;
    tick(2);
    na = 4'h0; nw = 1'b1; nd = 32'hFFFF_FFFF;
    tick(1);
    nw = 1'b0;
    tick(2);
    nb[2] = 1'b1; na = 4'h4;
    tick(10);
    nr = 1'b0;
    tick(1);
    nr = 1'b1;
    tick(25);
    nb[3] = 1'b1;
    tick(25);
    nb[3] = 1'b0;
    tick(25);
    nr = 1'b0;
    tick(2);
    nr = 1'b1;
    tick(25);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) if ($urandom_range(11) == 0) nb[i] = ~nb[i];
      if ($urandom_range(15) == 0) ns = $urandom;
      na = 4'($urandom);
      nw = ($urandom_range(7) == 0);
      nd = $urandom;
      nr = ($urandom_range(499) != 0);
      tick(1);
    end
    nw = 1'b0; nr = 1'b1;
    tick(1);
    for (int w = 0; w < 5 && q.size() != 0; w++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected results never compared, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
